cpu_dispatcher: RTL and testbench
=================================

# cpu_dispatcher

Bus dispatcher on the outside of the CPU array: arbitrates the shared external memory bus among `CPU_NUM` CPU bridges using round-robin token passing. Each bridge raises its dispatcher request; the dispatcher broadcasts the chosen CPU index with a one-cycle next-CPU strobe, holds the bus for that CPU until it releases, then rotates priority. Sits between the per-CPU bridge ports and the memory/bus mux, which it steers via `cpu_index` and `bus_busy`.

## Interface
- `CPU_NUM`, 4: number of CPUs served, legal 2..32.
- `HOLD_MAX`, 256: maximum HOLD cycles before a forced release (only with `DISPATCHER_TIMEOUT_EN`), legal 2..65535.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  `CPU_NUM`  per-CPU dispatcher request, level; bit i = CPU i.
- `done`  in  `CPU_NUM`  per-CPU release, level or pulse; bit i = CPU i.
- `next_cpu_q`  out  1  one-cycle grant strobe.
- `cpu_index`  out  32 (`DATA_SIZE0`+1)  granted CPU index; 32'hFFFFFFFF = none.
- `bus_busy`  out  1  bus owned by `cpu_index`.
- `grant_cnt`  out  16  count of grants issued, wraps.
- `timeout`  out  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT, HOLD, RELEASE. All outputs registered.
- Round-robin pointer `ptr` (0..CPU_NUM-1): winner = first i with `req[i]`=1 searching ptr, ptr+1, ... wrapping at CPU_NUM-1 to 0.
- IDLE: `cpu_index`=FFFFFFFF, `bus_busy`=0. If any `req` bit set -> GRANT with winner latched as `idx`; else stay.
- GRANT (exactly one cycle): `next_cpu_q`=1, `cpu_index`=`idx` zero-extended, `bus_busy`=1, `grant_cnt`+=1 (FFFF -> 0000) -> HOLD.
- HOLD: `next_cpu_q`=0, `cpu_index`=`idx`, `bus_busy`=1. Exit to RELEASE when `done[idx]`=1 or `req[idx]`=0. `done`/`req` bits of other CPUs ignored.
- RELEASE (one cycle): `bus_busy`=0, `cpu_index`=FFFFFFFF, `ptr`=(`idx`+1) mod CPU_NUM. Next: GRANT directly if any `req` set (arbitrated with updated `ptr`), else IDLE.
- Requester that is also current holder re-requesting after release is granted only after all other pending requesters ahead of it in rotation.

## Timing
- Reset values (edge with `rst`=1): state IDLE, `ptr`=0, `next_cpu_q`=0, `cpu_index`=FFFFFFFF, `bus_busy`=0, `grant_cnt`=0, `timeout`=0, hold counter 0.
- `rst` mid-GRANT/HOLD: ownership dropped at that edge, no RELEASE cycle, no `timeout` pulse.
- Latency: `req` sampled at edge E0 in IDLE -> GRANT outputs valid after E0; HOLD after E1.
- Release: `done[idx]` sampled at edge Ek -> `bus_busy`=0 after Ek; next grant strobe after Ek+1 at earliest. Minimum one idle bus cycle between owners.
- `done[idx]` already high during GRANT cycle: HOLD lasts exactly one cycle.
- Minimum grant period (back-to-back requesters): 3 cycles (GRANT, HOLD, RELEASE).

## Configuration
- `DISPATCHER_TIMEOUT_EN` defined: 16-bit hold counter cleared on GRANT, incremented each HOLD cycle; when count = `HOLD_MAX`-1 and no release condition -> RELEASE with `timeout`=1 for that RELEASE cycle, `ptr` advances normally. Release condition and counter limit on same edge -> normal release, `timeout`=0.
- Undefined: no counter, `timeout` tied 0, HOLD persists until `done[idx]` or `req[idx]` drop.

## Test plan
- Single requester: `req`=4'b0100 from reset -> strobe one cycle with `cpu_index`=2, `bus_busy`=1 until `done[2]`, then `cpu_index`=FFFFFFFF, `grant_cnt`=1.
- Round-robin: `req`=4'b1111 held, each holder asserts `done` after 2 HOLD cycles -> grant order 0,1,2,3,0; strobes 4 cycles apart.
- Wrap/priority: after grant to 3, `req`=4'b1001 -> next grant 0, then 3.
- Foreign done: holder 1, `done`=4'b0100 pulse -> ignored, `bus_busy` stays 1.
- Timeout (macro on, `HOLD_MAX`=8): holder 0 never releases -> `timeout` pulse on 9th cycle after strobe, next grant to 1; macro off -> bus held indefinitely.
- Reset mid-HOLD: `rst` during HOLD of CPU 2 -> next edge all outputs at reset values, following grant from `ptr`=0.

Source files
------------

// File: rtl/cpu_dispatcher.sv
// rtl/cpu_dispatcher.sv - round-robin external bus dispatcher for the CPU array (optional hold timeout: DISPATCHER_TIMEOUT_EN)
module cpu_dispatcher #(
`ifdef DISPATCHER_TIMEOUT_EN
    parameter int HOLD_MAX = 256,
`endif
    parameter int CPU_NUM  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CPU_NUM-1:0] req,
    input  logic [CPU_NUM-1:0] done,
    output logic               next_cpu_q,
    output logic [31:0]        cpu_index,
    output logic               bus_busy,
    output logic [15:0]        grant_cnt,
    output logic               timeout
);

    localparam int IDX_W = (CPU_NUM > 1) ? $clog2(CPU_NUM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CPU_NUM - 1);
    localparam logic [IDX_W:0]   IDX_NUM  = (IDX_W + 1)'(CPU_NUM);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] win;
    logic             any_req;
    logic             rel_cond;
    logic             force_rel;

    logic             next_cpu_d;
    logic [31:0]      cpu_index_d;
    logic             bus_busy_d;
    logic [15:0]      grant_cnt_d;
    logic             timeout_d;

    // Only the current holder's own done/req bits can end its tenure
    assign rel_cond = done[idx_q] | ~req[idx_q];

    // Round-robin search: first requester at or after ptr, wrapping at CPU_NUM-1
    always_comb begin
        logic [IDX_W:0] j;
        j       = '0;
        win     = ptr_q;
        any_req = 1'b0;
        for (int k = 0; k < CPU_NUM; k++) begin
            j = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (j >= IDX_NUM) begin
                j = j - IDX_NUM;
            end
            if (!any_req && req[j[IDX_W-1:0]]) begin
                any_req = 1'b1;
                win     = j[IDX_W-1:0];
            end
        end
    end

`ifdef DISPATCHER_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    logic [15:0] hold_cnt_q, hold_cnt_d;

    // A genuine release on the limit cycle wins over the forced one
    assign force_rel = (hold_cnt_q == HOLD_LAST) && !rel_cond;

    // Hold counter: cleared on grant, counts every HOLD cycle that stays in HOLD
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d == S_GRANT) begin
            hold_cnt_d = '0;
        end else if (state_q == S_HOLD && state_d == S_HOLD) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
        end
    end

    // Hold counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // State register plus arbitration bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; ptr moves past the holder as it enters RELEASE so the
    // RELEASE-cycle arbitration already sees the rotated priority
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE, S_RELEASE: begin
                if (any_req) begin
                    state_d = S_GRANT;
                    idx_d   = win;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (rel_cond || force_rel) begin
                    state_d = S_RELEASE;
                    ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so outputs align with state
    always_comb begin
        next_cpu_d  = (state_d == S_GRANT);
        bus_busy_d  = (state_d == S_GRANT) || (state_d == S_HOLD);
        cpu_index_d = bus_busy_d ? 32'(idx_d) : 32'hFFFF_FFFF;
        grant_cnt_d = grant_cnt + {15'd0, next_cpu_d};
        timeout_d   = (state_q == S_HOLD) && (state_d == S_RELEASE) && force_rel;
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            next_cpu_q <= 1'b0;
            cpu_index  <= 32'hFFFF_FFFF;
            bus_busy   <= 1'b0;
            grant_cnt  <= '0;
            timeout    <= 1'b0;
        end else begin
            next_cpu_q <= next_cpu_d;
            cpu_index  <= cpu_index_d;
            bus_busy   <= bus_busy_d;
            grant_cnt  <= grant_cnt_d;
            timeout    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_cpu_dispatcher.sv
// tb/tb_cpu_dispatcher.sv - self-checking bench for cpu_dispatcher
module tb_cpu_dispatcher;

    localparam int N  = 4;
    localparam int HM = 8;
`ifdef DISPATCHER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic         next_cpu_q;
    logic [31:0]  cpu_index;
    logic         bus_busy;
    logic [15:0]  grant_cnt;
    logic         timeout;

    always #5 clk = ~clk;

    cpu_dispatcher #(
`ifdef DISPATCHER_TIMEOUT_EN
        .HOLD_MAX(HM),
`endif
        .CPU_NUM(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .next_cpu_q(next_cpu_q),
        .cpu_index (cpu_index),
        .bus_busy  (bus_busy),
        .grant_cnt (grant_cnt),
        .timeout   (timeout)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: who owns the bus, whether this is the strobe cycle,
    // how long the owner has held, and where the rotation starts next time
    bit          chk_en = 1'b0;
    bit          m_busy, m_strobe, m_to;
    int          m_owner, m_ptr, m_holds;
    logic [15:0] m_cnt;

    always @(posedge clk) begin
        cyc++;
        m_to = 1'b0;
        if (rst) begin
            m_busy = 0; m_strobe = 0; m_ptr = 0; m_owner = 0; m_holds = 0;
            m_cnt = '0; chk_en = 1'b1;
        end else if (m_busy && m_strobe) begin
            m_strobe = 0;
            m_holds  = 0;
        end else if (m_busy) begin
            bit rel;
            rel = done[m_owner] || !req[m_owner];
            if (rel || (TO_EN && m_holds == HM - 1)) begin
                m_to   = !rel;
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else begin
                m_holds++;
            end
        end else if (req != '0) begin
            bit found;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            m_busy   = 1;
            m_strobe = 1;
            m_cnt    = m_cnt + 16'd1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("next_cpu_q", {31'd0, next_cpu_q}, {31'd0, m_strobe});
            check("cpu_index", cpu_index, m_busy ? 32'(m_owner) : 32'hFFFF_FFFF);
            check("bus_busy", {31'd0, bus_busy}, {31'd0, m_busy});
            check("grant_cnt", {16'd0, grant_cnt}, {16'd0, m_cnt});
            check("timeout", {31'd0, timeout}, {31'd0, m_to});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int last_strobe = 0;

    task automatic wait_strobe(input int exp_cpu, input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (next_cpu_q === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: no grant strobe within 40 cycles, expected cpu %0d", name, exp_cpu);
        end else begin
            check(name, cpu_index, 32'(exp_cpu));
            last_strobe = cyc;
        end
    endtask

    initial begin
        int order [5];
        int prev;
        order = '{0, 1, 2, 3, 0};

        // Reset values
        tick(2);
        check("rst_cpu_index", cpu_index, 32'hFFFF_FFFF);
        check("rst_grant_cnt", {16'd0, grant_cnt}, 32'd0);
        check("rst_bus_busy", {31'd0, bus_busy}, 32'd0);
        rst = 1'b0;

        // Single requester
        req = 4'b0100;
        wait_strobe(2, "single_grant");
        check("single_busy_grant", {31'd0, bus_busy}, 32'd1);
        tick(3);
        check("single_hold_idx", cpu_index, 32'd2);
        req  = 4'b0000;
        done = 4'b0100;
        tick(1);
        check("single_rel_busy", {31'd0, bus_busy}, 32'd0);
        check("single_rel_idx", cpu_index, 32'hFFFF_FFFF);
        check("single_cnt", {16'd0, grant_cnt}, 32'd1);
        done = '0;
        tick(1);

        // Round robin with all four requesting
        rst = 1'b1; tick(1); rst = 1'b0;
        req  = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_strobe(order[i], "rr_order");
            if (i > 0) check("rr_gap", 32'(last_strobe - prev), 32'd4);
            prev = last_strobe;
            if (i < 4) begin
                tick(2);
                done = 4'(1 << order[i]);
                tick(1);
                done = '0;
            end
        end
        req = '0;
        tick(3);

        // Wrap and re-request priority
        rst = 1'b1; tick(1); rst = 1'b0;
        req = 4'b1000;
        wait_strobe(3, "wrap_first");
        tick(1);
        req = 4'b1001;
        tick(1);
        done = 4'b1000;
        tick(1);
        done = '0;
        wait_strobe(0, "wrap_second");
        tick(1);
        done = 4'b0001;
        tick(1);
        done = '0;
        wait_strobe(3, "wrap_third");
        req = '0;
        tick(3);

        // done already high in the grant cycle: one HOLD cycle
        req = 4'b0001;
        wait_strobe(0, "early_done_grant");
        done = 4'b0001;
        tick(1);
        check("early_done_hold", {31'd0, bus_busy}, 32'd1);
        tick(1);
        check("early_done_rel", {31'd0, bus_busy}, 32'd0);
        req  = '0;
        done = '0;
        tick(2);

        // Foreign done is ignored
        req = 4'b0010;
        wait_strobe(1, "foreign_grant");
        tick(1);
        done = 4'b0100;
        tick(1);
        done = '0;
        check("foreign_busy", {31'd0, bus_busy}, 32'd1);
        check("foreign_idx", cpu_index, 32'd1);
        req = '0;
        tick(3);

        // Holder that never releases
        rst = 1'b1; tick(1); rst = 1'b0;
        req = 4'b0011;
        wait_strobe(0, "to_grant");
`ifdef DISPATCHER_TIMEOUT_EN
        tick(8);
        check("to_busy_before", {31'd0, bus_busy}, 32'd1);
        check("to_not_yet", {31'd0, timeout}, 32'd0);
        tick(1);
        check("to_pulse", {31'd0, timeout}, 32'd1);
        check("to_rel_busy", {31'd0, bus_busy}, 32'd0);
        wait_strobe(1, "to_next_grant");
`else
        tick(30);
        check("hold_forever_busy", {31'd0, bus_busy}, 32'd1);
        check("hold_forever_idx", cpu_index, 32'd0);
`endif
        req = '0;
        tick(3);

        // Reset in the middle of HOLD
        req = 4'b0100;
        wait_strobe(2, "rsthold_grant");
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rsthold_strobe", {31'd0, next_cpu_q}, 32'd0);
        check("rsthold_idx", cpu_index, 32'hFFFF_FFFF);
        check("rsthold_busy", {31'd0, bus_busy}, 32'd0);
        check("rsthold_cnt", {16'd0, grant_cnt}, 32'd0);
        check("rsthold_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        req = 4'b0101;
        wait_strobe(0, "rsthold_regrant");
        req = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
